// File: rtl/uart_pkg.sv
// Shared UART definitions. The transmitter uses the same defaults so both ends agree.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200
  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam int unsigned CNT_W            = 16;   // holds CLKS_PER_BIT up to 65535

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/shift_reg_serial_in_par_out.sv
// Serial-in / parallel-out register: right-shifting, new bit enters at the MSB,
// so after WIDTH shifts the first bit received sits at bit 0.
module shift_reg_serial_in_par_out
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_BITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             shift,
  output logic [WIDTH-1:0] bus_out
);

  logic [WIDTH-1:0] bus_q;

  // Shift one bit in from the top when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q <= '0;
    end else if (shift) begin
      bus_q <= {bit_in, bus_q[WIDTH-1:1]};
    end
  end

  assign bus_out = bus_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the line, detects the start bit, samples each bit at its
// centre and emits a one-cycle data_valid or frame_err pulse per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IdxLast  = 3'(DATA_BITS - 1);

  logic                 sync1_q, rxs_q, rxs_prev_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 shift_en;
  logic [DATA_BITS-1:0] sr_bus;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_in;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  shift_reg_serial_in_par_out #(
    .WIDTH(DATA_BITS)
  ) u_sipo (
    .clk    (clk),
    .reset  (reset),
    .bit_in (rxs_q),
    .shift  (shift_en),
    .bus_out(sr_bus)
  );

  // Next-state, bit timing and output pulse decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        // Edge, not level: a line stuck low never retriggers.
        if (rxs_prev_q && !rxs_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rxs_q ? StIdle : StData;  // high at mid-start is a glitch
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          idx_d    = idx_q + 3'd1;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rxs_q) begin
            data_d  = sr_bus;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random traffic, checked against a model that
// samples the recorded line waveform at bit centres.
module tb_uart_rx;

  localparam int C        = 16;
  localparam int H        = C / 2;
  localparam int NB       = 8;
  localparam int LatRxs   = H + (NB + 1) * C + 1;  // from rxs first low to pulse
  localparam int PulseOfs = 2 + LatRxs;            // from line first low to pulse

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_in;
  logic [NB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (NB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line/reset history, one entry per cycle, and observed output pulses.
  bit            line_q[$];
  bit            rst_q[$];
  int            ev_cyc[$];
  bit            ev_kind[$];  // 1 = frame_err
  logic [NB-1:0] ev_data[$];

  always @(negedge clk) begin
    if (data_valid === 1'b1 || frame_err === 1'b1) begin
      check_val("excl", {31'd0, data_valid & frame_err}, 32'd0);
      ev_cyc.push_back(line_q.size());
      ev_kind.push_back(frame_err);
      ev_data.push_back(data_out);
    end
    line_q.push_back(rx_in);
    rst_q.push_back(reset);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int gap, output int s);
    s = line_q.size();
    rx_in = 1'b0;
    tick(C);
    for (int k = 0; k < NB; k++) begin
      rx_in = d[k];
      tick(C);
    end
    rx_in = stop;
    tick(C);
    rx_in = 1'b1;
    tick(gap);
  endtask

  function automatic int find_ev(input int lo);
    for (int k = 0; k < ev_cyc.size(); k++) begin
      if (ev_cyc[k] >= lo) return k;
    end
    return -1;
  endfunction

  // Reference: walk the line history, find start edges, sample bit centres.
  int            m_cyc[$];
  bit            m_kind[$];
  logic [NB-1:0] m_data[$];
  logic [NB-1:0] m_good;

  task automatic run_model();
    int n, i, s, e, r, lim;
    bit prev, glitch;
    logic [NB-1:0] word;
    n = line_q.size();
    i = 0;
    prev = 1'b1;
    m_good = '0;
    while (i < n) begin
      if (rst_q[i]) begin
        prev = 1'b1;
        m_good = '0;
        i++;
        continue;
      end
      if (prev && !line_q[i]) begin
        s = i;
        e = s + H + (NB + 1) * C;
        if (e + 2 >= n) break;
        glitch = line_q[s + H];
        lim = glitch ? s + H : e + 2;
        r = -1;
        for (int k = s; k <= lim; k++) begin
          if (rst_q[k] && r < 0) r = k;
        end
        if (r >= 0) begin
          i = r;
          continue;
        end
        if (glitch) begin
          prev = 1'b1;
          i = s + H + 1;
          continue;
        end
        word = '0;
        for (int k = 0; k < NB; k++) word[k] = line_q[s + H + (k + 1) * C];
        if (line_q[e]) m_good = word;
        m_cyc.push_back(e + 3);
        m_kind.push_back(!line_q[e]);
        m_data.push_back(m_good);
        prev = line_q[e];
        i = e + 1;
        continue;
      end
      prev = line_q[i];
      i++;
    end
  endtask

  initial begin
    int s0, s1, j0, j1, nb, cnt, len;
    logic [7:0] d;

    reset = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    tick(2);
    reset = 1'b0;
    check_val("rst_data", 32'(data_out), 32'h0);
    check_val("rst_valid", 32'(data_valid), 32'h0);
    check_val("rst_ferr", 32'(frame_err), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    tick(20);

    // Single good frame.
    nb = ev_cyc.size();
    send_frame(8'hA5, 1'b1, 20, s0);
    check_val("a5_pulses", ev_cyc.size() - nb, 1);
    check_val("a5_data", 32'(data_out), 32'hA5);
    check_val("a5_busy", 32'(busy), 32'h0);

    // Back-to-back with no idle gap.
    send_frame(8'h00, 1'b1, 0, s0);
    send_frame(8'hFF, 1'b1, 30, s1);
    j0 = find_ev(s0);
    j1 = find_ev(s1);
    check_val("b2b_found", 32'((j0 >= 0) && (j1 > j0)), 32'h1);
    if (j0 >= 0 && j1 > j0) begin
      check_val("b2b_gap", ev_cyc[j1] - ev_cyc[j0], 160);
      check_val("b2b_d0", 32'(ev_data[j0]), 32'h00);
      check_val("b2b_d1", 32'(ev_data[j1]), 32'hFF);
    end

    // Framing error keeps data_out, then a clean frame.
    nb = ev_cyc.size();
    send_frame(8'h3C, 1'b0, 30, s0);
    check_val("ferr_pulses", ev_cyc.size() - nb, 1);
    if (ev_cyc.size() > nb) check_val("ferr_kind", 32'(ev_kind[nb]), 32'h1);
    check_val("ferr_hold", 32'(data_out), 32'hFF);
    send_frame(8'h3C, 1'b1, 30, s0);
    check_val("after_ferr", 32'(data_out), 32'h3C);

    // Start-bit glitch: busy only while in START.
    nb = ev_cyc.size();
    cnt = 0;
    rx_in = 1'b0;
    for (int k = 0; k < 44; k++) begin
      if (k == 4) rx_in = 1'b1;
      tick(1);
      if (busy) cnt++;
    end
    check_val("glitch_busy", cnt, H);
    check_val("glitch_nopulse", ev_cyc.size() - nb, 0);

    // Reset mid-frame after data bit 3 of 0x5A.
    nb = ev_cyc.size();
    d = 8'h5A;
    rx_in = 1'b0;
    tick(C);
    for (int k = 0; k < 4; k++) begin
      rx_in = d[k];
      tick(C);
    end
    reset = 1'b1;
    rx_in = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("mrst_data", 32'(data_out), 32'h0);
    check_val("mrst_valid", 32'(data_valid), 32'h0);
    check_val("mrst_ferr", 32'(frame_err), 32'h0);
    check_val("mrst_busy", 32'(busy), 32'h0);
    tick(200);
    check_val("mrst_nopulse", ev_cyc.size() - nb, 0);
    send_frame(8'h5A, 1'b1, 30, s0);
    check_val("mrst_next", 32'(data_out), 32'h5A);

    // Fixed latency on 0x81.
    send_frame(8'h81, 1'b1, 30, s0);
    j0 = find_ev(s0);
    check_val("lat_found", 32'(j0 >= 0), 32'h1);
    if (j0 >= 0) check_val("lat_81", ev_cyc[j0] - s0 - 2, 8 + 9 * 16 + 1);

    // Random traffic: frames with occasional bad stop bits, gaps and glitches.
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(1, 6);
        rx_in = 1'b0;
        tick(len);
        rx_in = 1'b1;
        tick(20);
      end else begin
        d = 8'($urandom);
        send_frame(d, ($urandom_range(0, 4) != 0), $urandom_range(0, 24), s0);
      end
    end
    rx_in = 1'b1;
    tick(200);

    run_model();
    check_val("ev_count", ev_cyc.size(), m_cyc.size());
    for (int k = 0; k < ev_cyc.size() && k < m_cyc.size(); k++) begin
      check_val($sformatf("ev%0d_cyc", k), ev_cyc[k], m_cyc[k]);
      check_val($sformatf("ev%0d_kind", k), 32'(ev_kind[k]), 32'(m_kind[k]));
      check_val($sformatf("ev%0d_data", k), 32'(ev_data[k]), 32'(m_data[k]));
    end
    check_val("end_data", 32'(data_out), 32'(m_good));
    check_val("end_busy", 32'(busy), 32'h0);
    check_val("end_model_pulse", {31'd0, PulseOfs == 155}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
